// File: rtl/bicubic_out_serializer.sv
// Serializes 4-pixel bicubic groups into a 1-pixel/cycle valid/ready stream with frame/row markers.
// Optional stall counter port perf_stall_cnt when BCCI_SER_PERF_EN is defined.
module bicubic_out_serializer #(
    parameter int unsigned CHANNEL_WIDTH  = 8,
    parameter int unsigned SRC_IMG_WIDTH  = 960,
    parameter int unsigned SRC_IMG_HEIGHT = 540
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bcci_rsp_valid,
    output logic                     bf_rsp_ready,
    input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data1,
    input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data2,
    input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data3,
    input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data4,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHANNEL_WIDTH-1:0] out_data,
    output logic                     out_user,
    output logic                     out_last,
    output logic                     frame_done
`ifdef BCCI_SER_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int unsigned GROUP_W  = 4 * CHANNEL_WIDTH;
    localparam int unsigned DST_ROWS = 4 * SRC_IMG_HEIGHT;
    localparam int unsigned GRP_W    = (SRC_IMG_WIDTH > 1) ? $clog2(SRC_IMG_WIDTH) : 1;
    localparam int unsigned ROW_W    = (DST_ROWS > 1) ? $clog2(DST_ROWS) : 1;

    logic [GROUP_W-1:0]       mem0;
    logic [GROUP_W-1:0]       mem1;
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;
    logic [1:0]               sub;
    logic [GRP_W-1:0]         grp;
    logic [ROW_W-1:0]         row;
    logic                     frame_done_q;

    logic                     in_hs;
    logic                     out_hs;
    logic                     pop;
    logic                     at_last_grp;
    logic                     at_last_row;
    logic [GROUP_W-1:0]       head;
    logic [CHANNEL_WIDTH-1:0] head_pix;

    // Flow control depends only on registered occupancy and reset, never on out_ready.
    assign bf_rsp_ready = (count != 2'd2) & ~rst;
    assign out_valid    = (count != 2'd0) & ~rst;
    assign in_hs        = bcci_rsp_valid & bf_rsp_ready;
    assign out_hs       = out_valid & out_ready;
    assign pop          = out_hs & (sub == 2'd3);
    assign at_last_grp  = (grp == GRP_W'(SRC_IMG_WIDTH - 1));
    assign at_last_row  = (row == ROW_W'(DST_ROWS - 1));
    assign head         = rd_ptr ? mem1 : mem0;

    // data1 sits in the most significant slice of a stored group.
    always_comb begin
        head_pix = '0;
        case (sub)
            2'd0:    head_pix = head[3*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            2'd1:    head_pix = head[2*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            2'd2:    head_pix = head[1*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            default: head_pix = head[0 +: CHANNEL_WIDTH];
        endcase
    end

    assign out_data   = out_valid ? head_pix : '0;
    assign out_user   = out_valid & (row == '0) & (grp == '0) & (sub == 2'd0);
    assign out_last   = out_valid & (sub == 2'd3) & at_last_grp;
    assign frame_done = frame_done_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            sub          <= 2'd0;
            grp          <= '0;
            row          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (in_hs) wr_ptr <= ~wr_ptr;
            if (pop)   rd_ptr <= ~rd_ptr;
            case ({in_hs, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (out_hs) sub <= sub + 2'd1;
            // Position counters advance once per fully emitted group.
            if (pop) begin
                if (at_last_grp) begin
                    grp <= '0;
                    row <= at_last_row ? '0 : row + ROW_W'(1);
                end else begin
                    grp <= grp + GRP_W'(1);
                end
            end
            frame_done_q <= out_hs & out_last & at_last_row;
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs && !wr_ptr) mem0 <= {bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4};
        if (in_hs &&  wr_ptr) mem1 <= {bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4};
    end

`ifdef BCCI_SER_PERF_EN
    // Saturating count of cycles where a pixel waits on the sink.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bicubic_out_serializer.sv
// Directed self-checking bench for bicubic_out_serializer (4x2 source image, 8-bit pixels).
module tb_bicubic_out_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bcci_rsp_valid = 1'b0;
    logic       bf_rsp_ready;
    logic [7:0] bcci_rsp_data1 = '0;
    logic [7:0] bcci_rsp_data2 = '0;
    logic [7:0] bcci_rsp_data3 = '0;
    logic [7:0] bcci_rsp_data4 = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_user;
    logic       out_last;
    logic       frame_done;
`ifdef BCCI_SER_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int p, fd_cnt, fd_p1, fd_p2, gaps;

    bicubic_out_serializer #(
        .CHANNEL_WIDTH (8),
        .SRC_IMG_WIDTH (4),
        .SRC_IMG_HEIGHT(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bcci_rsp_valid(bcci_rsp_valid),
        .bf_rsp_ready  (bf_rsp_ready),
        .bcci_rsp_data1(bcci_rsp_data1),
        .bcci_rsp_data2(bcci_rsp_data2),
        .bcci_rsp_data3(bcci_rsp_data3),
        .bcci_rsp_data4(bcci_rsp_data4),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_user      (out_user),
        .out_last      (out_last),
        .frame_done    (frame_done)
`ifdef BCCI_SER_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_group(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        bcci_rsp_data1 = a;
        bcci_rsp_data2 = b;
        bcci_rsp_data3 = c;
        bcci_rsp_data4 = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bcci_rsp_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(bf_rsp_ready), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(bf_rsp_ready), 32'd1);
        chk("rel_valid", 32'(out_valid), 32'd0);
    endtask

    // Streams groups whose pixel k (1-based) carries base+k; stops early when max_pix pixels seen.
    task automatic stream_check(input int ngroups, input int max_pix, input logic [7:0] base);
        int g;
        bit acc;
        g = 0; p = 0; fd_cnt = 0; fd_p1 = 0; fd_p2 = 0; gaps = 0;
        out_ready = 1'b1;
        set_group(8'(base + 1), 8'(base + 2), 8'(base + 3), 8'(base + 4));
        bcci_rsp_valid = 1'b1;
        for (int cyc = 0; cyc < 4 * ngroups + 20; cyc++) begin
            if (frame_done) begin
                fd_cnt++;
                if (fd_cnt == 1) fd_p1 = p; else fd_p2 = p;
            end
            if (out_valid) begin
                p++;
                chk("px_data", 32'(out_data), 32'(8'(base + p)));
                chk("px_user", 32'(out_user), 32'((p % 128) == 1));
                chk("px_last", 32'(out_last), 32'((p % 16) == 0));
            end else if (p > 0 && p < 4 * ngroups) begin
                gaps++;
            end
            if (p == max_pix) return;
            acc = bcci_rsp_valid && bf_rsp_ready;
            @(negedge clk);
            if (acc) begin
                g++;
                if (g < ngroups)
                    set_group(8'(base + 4*g + 1), 8'(base + 4*g + 2), 8'(base + 4*g + 3), 8'(base + 4*g + 4));
                else
                    bcci_rsp_valid = 1'b0;
            end
        end
    endtask

    logic [7:0] exp1 [4];
    logic [7:0] exp2 [12];
    int got_c;

    initial begin
        exp1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                 8'h99, 8'hAA, 8'hBB, 8'hCC};

        // Single group, no backpressure
        do_reset();
        set_group(8'h11, 8'h22, 8'h33, 8'h44);
        bcci_rsp_valid = 1'b1;
        out_ready = 1'b1;
        chk("t1_ready", 32'(bf_rsp_ready), 32'd1);
        @(negedge clk);
        bcci_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_data", 32'(out_data), 32'(exp1[i]));
            chk("t1_user", 32'(out_user), 32'(i == 0));
            chk("t1_last", 32'(out_last), 32'd0);
            @(negedge clk);
        end
        chk("t1_idle", 32'(out_valid), 32'd0);

        // Backpressure: two groups fill the buffer, third waits
        do_reset();
        set_group(8'h11, 8'h22, 8'h33, 8'h44);
        bcci_rsp_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready1", 32'(bf_rsp_ready), 32'd1);
        set_group(8'h55, 8'h66, 8'h77, 8'h88);
        @(negedge clk);
        set_group(8'h99, 8'hAA, 8'hBB, 8'hCC);
        for (int i = 0; i < 3; i++) begin
            chk("bp_full", 32'(bf_rsp_ready), 32'd0);
            chk("bp_hold_v", 32'(out_valid), 32'd1);
            chk("bp_hold_d", 32'(out_data), 32'h11);
            chk("bp_hold_u", 32'(out_user), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        got_c = -1;
        for (int c = 0; c < 12; c++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'(exp2[c]));
            if (bcci_rsp_valid && bf_rsp_ready) got_c = c;
            @(negedge clk);
            if (got_c >= 0) bcci_rsp_valid = 1'b0;
        end
        chk("bp_accept_cyc", 32'(got_c), 32'd4);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Framing and full rate over two 128-pixel frames
        do_reset();
        stream_check(64, -1, 8'h00);
        chk("fr_pixels", 32'(p), 32'd256);
        chk("fr_gaps", 32'(gaps), 32'd0);
        chk("fr_fd_cnt", 32'(fd_cnt), 32'd2);
        chk("fr_fd_at1", 32'(fd_p1), 32'd128);
        chk("fr_fd_at2", 32'(fd_p2), 32'd256);

        // Reset mid-row, then restart framing
        do_reset();
        stream_check(64, 6, 8'h00);
        rst = 1'b1;
        bcci_rsp_valid = 1'b0;
        @(negedge clk);
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_ready", 32'(bf_rsp_ready), 32'd0);
        chk("mr_data", 32'(out_data), 32'd0);
        chk("mr_user", 32'(out_user), 32'd0);
        chk("mr_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_rel_ready", 32'(bf_rsp_ready), 32'd1);
        stream_check(8, -1, 8'hA0);
        chk("mr_pixels", 32'(p), 32'd32);
        chk("mr_fd_cnt", 32'(fd_cnt), 32'd0);

`ifdef BCCI_SER_PERF_EN
        // Stall counter
        do_reset();
        chk("perf_rst", perf_stall_cnt, 32'd0);
        set_group(8'h11, 8'h22, 8'h33, 8'h44);
        bcci_rsp_valid = 1'b1;
        @(negedge clk);
        bcci_rsp_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("perf_cnt", perf_stall_cnt, 32'd10);
        out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("perf_clr", perf_stall_cnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
